// File: rtl/env_playback_seq_pkg.sv
// Shared definitions for the playback read sequencer and its RAM wrapper.
//   seqState_t         : sequencer state encoding (IDLE / RUN / DRAIN)
//   RD_LATENCY_DEFAULT : addr-to-rdata latency of the sample RAM read port;
//                        the RAM wrapper uses the same constant so both agree
//   lenWidthFor()      : length field width able to express a full 2^addrWidth run
package env_playback_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seqState_t;

  localparam int RD_LATENCY_DEFAULT = 3;

  // One extra bit so that a length of exactly 2^addrWidth fits.
  function automatic int lenWidthFor(input int addrWidth);
    return addrWidth + 1;
  endfunction

endpackage

// File: rtl/env_playback_seq_valid_delay_line.sv
// Fixed-depth shift register carrying per-issue qualifier bits ({last,valid})
// alongside the RAM read pipeline so they line up with the returning data.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears every stage
//   clear : synchronous clear of every stage (used to drop in-flight issues)
//   din   : bits entering stage 0
//   dout  : bits leaving the last stage, DEPTH cycles after entry
module valid_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stageReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stageReg <= '0;
    end else if (clear) begin
      stageReg <= '0;
    end else begin
      stageReg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stageReg[i] <= stageReg[i-1];
      end
    end
  end

  assign dout = stageReg[DEPTH-1];

endmodule

// File: rtl/env_playback_seq.sv
// Read-side playback sequencer for the sample RAM narrow read port.
// A start command issues a contiguous run of read addresses (one per cycle,
// wrapping modulo 2^ADDRWIDTH) and re-aligns the returning RAM data into a
// valid-qualified sample stream with last/done/busy status.
//   clk, rst            : clock, asynchronous active-high reset
//   start, start_addr,
//   length              : run command; accepted only while idle
//   abort               : cancels the run in progress, dropping in-flight samples
//   addr                : registered read address to the RAM
//   rdata               : RAM read data, RD_LATENCY cycles after addr
//   dout, dout_valid,
//   dout_last           : registered output sample stream
//   busy                : run in progress
//   done                : one-cycle pulse coincident with dout_last
module env_playback_seq
  import env_playback_seq_pkg::*;
#(
  parameter int ADDRWIDTH  = 10,
  parameter int DATAWIDTH  = 4,
  parameter int LENWIDTH   = lenWidthFor(ADDRWIDTH),
  parameter int RD_LATENCY = RD_LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] start_addr,
  input  logic [LENWIDTH-1:0]  length,
  input  logic                 abort,
  output logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] rdata,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 done
);

  seqState_t            stateReg, stateNext;
  logic [LENWIDTH-1:0]  remainReg, remainNext;
  logic [ADDRWIDTH-1:0] addrReg, addrNext;
  // Issue flags are registered together with addr so they describe the
  // address currently presented to the RAM.
  logic                 issueValidReg, issueValidNext;
  logic                 issueLastReg, issueLastNext;
  // Zero-length start: no samples, but last/done still pulse once.
  logic                 zeroPulseReg, zeroPulseNext;
  logic                 lineClear;
  logic [1:0]           lineOut;
  logic [DATAWIDTH-1:0] doutReg;

  always_comb begin
    stateNext      = stateReg;
    remainNext     = remainReg;
    addrNext       = addrReg;
    issueValidNext = 1'b0;
    issueLastNext  = 1'b0;
    zeroPulseNext  = 1'b0;
    lineClear      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start && !abort) begin
          if (length == '0) begin
            zeroPulseNext = 1'b1;
          end else begin
            addrNext       = start_addr;
            remainNext     = length - 1'b1;
            issueValidNext = 1'b1;
            issueLastNext  = (length == LENWIDTH'(1));
            stateNext      = (length == LENWIDTH'(1)) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          stateNext = IDLE;
          lineClear = 1'b1;
        end else begin
          // remainReg counts issues still owed after the current one; it is
          // always >= 1 while in RUN.
          addrNext       = addrReg + 1'b1;
          remainNext     = remainReg - 1'b1;
          issueValidNext = 1'b1;
          issueLastNext  = (remainReg == LENWIDTH'(1));
          if (remainReg == LENWIDTH'(1)) begin
            stateNext = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          stateNext = IDLE;
          lineClear = 1'b1;
        end else if (lineOut[1]) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        lineClear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg      <= IDLE;
      remainReg     <= '0;
      addrReg       <= '0;
      issueValidReg <= 1'b0;
      issueLastReg  <= 1'b0;
      zeroPulseReg  <= 1'b0;
      doutReg       <= '0;
    end else begin
      stateReg      <= stateNext;
      remainReg     <= remainNext;
      addrReg       <= addrNext;
      issueValidReg <= issueValidNext;
      issueLastReg  <= issueLastNext;
      zeroPulseReg  <= zeroPulseNext;
      doutReg       <= rdata;
    end
  end

  // RD_LATENCY stages cover the RAM pipeline, one more covers the dout register.
  valid_delay_line #(
    .DEPTH(RD_LATENCY + 1),
    .WIDTH(2)
  ) uLine (
    .clk  (clk),
    .rst  (rst),
    .clear(lineClear),
    .din  ({issueLastReg, issueValidReg}),
    .dout (lineOut)
  );

  assign addr       = addrReg;
  assign dout       = doutReg;
  assign dout_valid = lineOut[0];
  assign dout_last  = lineOut[1] | zeroPulseReg;
  assign done       = dout_last;
  assign busy       = (stateReg != IDLE);

endmodule

// File: tb/tb_env_playback_seq.sv
module tb_env_playback_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  start_addr;
  logic [10:0] length;
  logic        abort;
  logic [9:0]  addr;
  logic [3:0]  rdata;
  logic [3:0]  dout;
  logic        dout_valid;
  logic        dout_last;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] d;
    logic       last;
  } exp_t;
  exp_t sbq[$];

  env_playback_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .abort     (abort),
    .addr      (addr),
    .rdata     (rdata),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: low nibble XOR top nibble of the address.
  function automatic logic [3:0] ramVal(input logic [9:0] a);
    return a[3:0] ^ a[9:6];
  endfunction

  // Sample RAM read port model with 3-cycle latency.
  logic [3:0] ramP1, ramP2;
  always @(posedge clk) begin
    ramP1 <= ramVal(addr);
    ramP2 <= ramP1;
    rdata <= ramP2;
  end

  task automatic pushRun(input logic [9:0] sa, input int len);
    exp_t e;
    logic [9:0] a;
    for (int i = 0; i < len; i++) begin
      a = sa + 10'(i);
      e.d = ramVal(a);
      e.last = (i == len - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; start_addr = '0; length = '0; abort = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (addr !== 10'h0) begin miscompares++; $display("FAIL reset addr got %h exp 000", addr); end
    vectors++; if (dout !== 4'h0) begin miscompares++; $display("FAIL reset dout got %h exp 0", dout); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset dout_valid got %b exp 0", dout_valid); end
    vectors++; if (dout_last !== 1'b0) begin miscompares++; $display("FAIL reset dout_last got %b exp 0", dout_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done got %b exp 0", done); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_release busy/valid got %b/%b exp 0/0", busy, dout_valid); end
    $display("reset checked");
  endtask

  task automatic test_runs();
    logic [9:0] tAddr[5] = '{10'h010, 10'h3FE, 10'h155, 10'h200, 10'h3F0};
    int tLen[5] = '{4, 4, 1, 20, 1030};
    logic [9:0] sa, expAddr;
    int len;
    logic expValid, expLast;
    exp_t e;
    for (int t = 0; t < 5; t++) begin
      sa = tAddr[t];
      len = tLen[t];
      pushRun(sa, len);
      start = 1'b1; start_addr = sa; length = 11'(len);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= len + 6; c++) begin
        expValid = (c >= 5 && c <= len + 4);
        expLast = (c == len + 4);
        vectors++; if (dout_valid !== expValid) begin miscompares++; $display("FAIL run%0d valid c=%0d got %b exp %b", t, c, dout_valid, expValid); end
        vectors++; if (done !== expLast || dout_last !== expLast) begin miscompares++; $display("FAIL run%0d done/last c=%0d got %b/%b exp %b", t, c, done, dout_last, expLast); end
        vectors++; if (busy !== (c <= len + 4)) begin miscompares++; $display("FAIL run%0d busy c=%0d got %b exp %b", t, c, busy, (c <= len + 4)); end
        if (c <= len + 4) begin
          expAddr = sa + 10'(((c < len) ? c : len) - 1);
          vectors++; if (addr !== expAddr) begin miscompares++; $display("FAIL run%0d addr c=%0d got %h exp %h", t, c, addr, expAddr); end
        end
        if (dout_valid === 1'b1 && sbq.size() != 0) begin
          e = sbq.pop_front();
          vectors++; if (dout !== e.d || dout_last !== e.last) begin miscompares++; $display("FAIL run%0d data c=%0d got %h/%b exp %h/%b", t, c, dout, dout_last, e.d, e.last); end
        end
        @(negedge clk);
      end
      vectors++; if (sbq.size() != 0) begin miscompares++; $display("FAIL run%0d leftover got %0d exp 0", t, sbq.size()); end
      sbq.delete();
      $display("run start_addr=%h length=%0d", sa, len);
    end
  endtask

  task automatic test_zero_length();
    start = 1'b1; start_addr = 10'h123; length = 11'd0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      vectors++; if (done !== (c == 1) || dout_last !== (c == 1)) begin miscompares++; $display("FAIL zero_len done/last c=%0d got %b/%b exp %b", c, done, dout_last, (c == 1)); end
      vectors++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_len valid/busy c=%0d got %b/%b exp 0/0", c, dout_valid, busy); end
      @(negedge clk);
    end
    $display("zero-length start checked");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int nValid = 0;
    pushRun(10'h040, 8);
    start = 1'b1; start_addr = 10'h040; length = 11'd8;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      vectors++; if (dout_valid !== (c >= 5 && c <= 12)) begin miscompares++; $display("FAIL busy_start valid c=%0d got %b exp %b", c, dout_valid, (c >= 5 && c <= 12)); end
      vectors++; if (busy !== (c <= 12)) begin miscompares++; $display("FAIL busy_start busy c=%0d got %b exp %b", c, busy, (c <= 12)); end
      if (dout_valid === 1'b1) begin
        nValid++;
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          vectors++; if (dout !== e.d || dout_last !== e.last) begin miscompares++; $display("FAIL busy_start data c=%0d got %h/%b exp %h/%b", c, dout, dout_last, e.d, e.last); end
        end
      end
      start = (c == 3);
      start_addr = 10'h300; length = 11'd5;
      @(negedge clk);
    end
    start = 1'b0;
    vectors++; if (nValid != 8) begin miscompares++; $display("FAIL busy_start count got %0d exp 8", nValid); end
    sbq.delete();
    $display("start while busy ignored, valids=%0d", nValid);
    pushRun(10'h300, 3);
    start = 1'b1; start_addr = 10'h300; length = 11'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      vectors++; if (dout_valid !== (c >= 5 && c <= 7)) begin miscompares++; $display("FAIL next_run valid c=%0d got %b exp %b", c, dout_valid, (c >= 5 && c <= 7)); end
      vectors++; if (busy !== (c <= 7)) begin miscompares++; $display("FAIL next_run busy c=%0d got %b exp %b", c, busy, (c <= 7)); end
      if (dout_valid === 1'b1 && sbq.size() != 0) begin
        e = sbq.pop_front();
        vectors++; if (dout !== e.d || dout_last !== e.last) begin miscompares++; $display("FAIL next_run data c=%0d got %h/%b exp %h/%b", c, dout, dout_last, e.d, e.last); end
      end
      @(negedge clk);
    end
    vectors++; if (sbq.size() != 0) begin miscompares++; $display("FAIL next_run leftover got %0d exp 0", sbq.size()); end
    sbq.delete();
    $display("follow-on run start_addr=300 length=3");
  endtask

  task automatic test_abort();
    exp_t e;
    pushRun(10'h080, 16);
    start = 1'b1; start_addr = 10'h080; length = 11'd16;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      vectors++; if (dout_valid !== (c == 5 || c == 6)) begin miscompares++; $display("FAIL abort valid c=%0d got %b exp %b", c, dout_valid, (c == 5 || c == 6)); end
      vectors++; if (busy !== (c <= 6)) begin miscompares++; $display("FAIL abort busy c=%0d got %b exp %b", c, busy, (c <= 6)); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort done c=%0d got %b exp 0", c, done); end
      if (dout_valid === 1'b1 && sbq.size() != 0) begin
        e = sbq.pop_front();
        vectors++; if (dout !== e.d) begin miscompares++; $display("FAIL abort data c=%0d got %h exp %h", c, dout, e.d); end
      end
      abort = (c == 6);
      @(negedge clk);
    end
    abort = 1'b0;
    sbq.delete();
    $display("abort at cycle 6 of 16-sample run");
    start = 1'b1; abort = 1'b1; start_addr = 10'h010; length = 11'd4;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      vectors++; if (busy !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_start c=%0d busy/valid/done got %b/%b/%b exp 0/0/0", c, busy, dout_valid, done); end
      @(negedge clk);
    end
    $display("abort with start in idle ignored");
  endtask

  task automatic test_async_reset();
    exp_t e;
    pushRun(10'h0C0, 16);
    start = 1'b1; start_addr = 10'h0C0; length = 11'd16;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      vectors++; if (dout_valid !== (c >= 5)) begin miscompares++; $display("FAIL arst_pre valid c=%0d got %b exp %b", c, dout_valid, (c >= 5)); end
      if (dout_valid === 1'b1 && sbq.size() != 0) begin
        e = sbq.pop_front();
        vectors++; if (dout !== e.d) begin miscompares++; $display("FAIL arst_pre data c=%0d got %h exp %h", c, dout, e.d); end
      end
      if (c < 9) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    vectors++; if (addr !== 10'h0 || dout !== 4'h0) begin miscompares++; $display("FAIL arst addr/dout got %h/%h exp 000/0", addr, dout); end
    vectors++; if (dout_valid !== 1'b0 || dout_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL arst flags valid/last/busy/done got %b/%b/%b/%b exp 0/0/0/0", dout_valid, dout_last, busy, done); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    pushRun(10'h020, 2);
    start = 1'b1; start_addr = 10'h020; length = 11'd2;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      vectors++; if (dout_valid !== (c == 5 || c == 6)) begin miscompares++; $display("FAIL arst_post valid c=%0d got %b exp %b", c, dout_valid, (c == 5 || c == 6)); end
      vectors++; if (done !== (c == 6)) begin miscompares++; $display("FAIL arst_post done c=%0d got %b exp %b", c, done, (c == 6)); end
      vectors++; if (busy !== (c <= 6)) begin miscompares++; $display("FAIL arst_post busy c=%0d got %b exp %b", c, busy, (c <= 6)); end
      if (dout_valid === 1'b1 && sbq.size() != 0) begin
        e = sbq.pop_front();
        vectors++; if (dout !== e.d || dout_last !== e.last) begin miscompares++; $display("FAIL arst_post data c=%0d got %h/%b exp %h/%b", c, dout, dout_last, e.d, e.last); end
      end
      @(negedge clk);
    end
    vectors++; if (sbq.size() != 0) begin miscompares++; $display("FAIL arst_post leftover got %0d exp 0", sbq.size()); end
    sbq.delete();
    $display("async reset mid-run, then run start_addr=020 length=2");
  endtask

  initial begin
    test_reset();
    test_runs();
    test_zero_length();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
